// File: rtl/reg_enable_pkg.sv
// Shared mode constants and FSM state encoding for the register-enable sequencer.
package reg_enable_pkg;

  localparam logic [1:0] MODE_SINGLE = 2'b00;
  localparam logic [1:0] MODE_SWEEP  = 2'b01;
  localparam logic [1:0] MODE_BCAST  = 2'b10;
  localparam logic [1:0] MODE_RSVD   = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    SINGLE = 2'b01,
    SWEEP  = 2'b10,
    BCAST  = 2'b11
  } state_e;

endpackage

// File: rtl/reg_enable_sequencer_if.sv
// Request handshake and enable-vector bundle between a requester and the sequencer.
interface reg_enable_sequencer_if #(
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned NUM_REGS = 16
);
  logic                req_valid;
  logic                req_ready;
  logic [ADDR_W-1:0]   req_addr;
  logic [1:0]          req_mode;
  logic [NUM_REGS-1:0] enables;
  logic                en_valid;
  logic                busy;
  logic                err;

  modport master (
    output req_valid, req_addr, req_mode,
    input  req_ready, enables, en_valid, busy, err
  );

  modport slave (
    input  req_valid, req_addr, req_mode,
    output req_ready, enables, en_valid, busy, err
  );
endinterface

// File: rtl/reg_enable_sequencer_onehot_decode.sv
// Combinational address-to-one-hot decoder; addresses at or beyond NUM_REGS decode to zero.
module onehot_decode #(
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned NUM_REGS  = 16,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic [ADDR_W-1:0]   addr,
  output logic [NUM_REGS-1:0] onehot
);
  localparam int unsigned AW1 = ADDR_W + 1;

  // Legacy ordering puts address 0 on the top enable line.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_bit
    localparam int unsigned POS = (MSB_FIRST != 0) ? (NUM_REGS - 1 - i) : i;
    assign onehot[POS] = ({1'b0, addr} == AW1'(i));
  end
endmodule

// File: rtl/reg_enable_sequencer.sv
// Registered register-enable sequencer: single, broadcast and sweep writes over valid/ready.
module reg_enable_sequencer
  import reg_enable_pkg::*;
#(
  parameter int unsigned ADDR_W    = 4,
  parameter int unsigned NUM_REGS  = 16,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  reg_enable_sequencer_if.slave bus
);
  localparam int unsigned       AW1  = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

  state_e              state;
  logic [ADDR_W-1:0]   cnt;
  logic [ADDR_W-1:0]   sel_addr;
  logic [NUM_REGS-1:0] dec;
  logic [NUM_REGS-1:0] enables_q;
  logic                en_valid_q;
  logic                err_q;
  logic                ready_c;
  logic                accept_c;
  logic                in_range_c;

  // Sweeps hold off new work until their final register is being driven.
  assign ready_c    = !rst && ((state != SWEEP) || (cnt == LAST));
  assign accept_c   = bus.req_valid && ready_c;
  assign in_range_c = ({1'b0, bus.req_addr} < AW1'(NUM_REGS));

  // Decode whichever index will be on the enables next cycle.
  always_comb begin
    sel_addr = cnt + ADDR_W'(1);
    if (accept_c) begin
      sel_addr = (bus.req_mode == MODE_SWEEP) ? '0 : bus.req_addr;
    end
  end

  onehot_decode #(
    .ADDR_W   (ADDR_W),
    .NUM_REGS (NUM_REGS),
    .MSB_FIRST(MSB_FIRST)
  ) u_decode (
    .addr  (sel_addr),
    .onehot(dec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      enables_q  <= '0;
      en_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      enables_q  <= '0;
      en_valid_q <= 1'b0;
      err_q      <= 1'b0;
      if (accept_c) begin
        case (bus.req_mode)
          MODE_SINGLE: begin
            if (in_range_c) begin
              state      <= SINGLE;
              enables_q  <= dec;
              en_valid_q <= 1'b1;
            end else begin
              state <= IDLE;
              err_q <= 1'b1;
            end
          end
          MODE_SWEEP: begin
            state      <= SWEEP;
            cnt        <= '0;
            enables_q  <= dec;
            en_valid_q <= 1'b1;
          end
          MODE_BCAST: begin
            state      <= BCAST;
            enables_q  <= '1;
            en_valid_q <= 1'b1;
          end
          default: begin
            state <= IDLE;
            err_q <= 1'b1;
          end
        endcase
      end else if ((state == SWEEP) && (cnt != LAST)) begin
        cnt        <= cnt + ADDR_W'(1);
        enables_q  <= dec;
        en_valid_q <= 1'b1;
      end else begin
        state <= IDLE;
      end
    end
  end

  assign bus.req_ready = ready_c;
  assign bus.enables   = enables_q;
  assign bus.en_valid  = en_valid_q;
  assign bus.err       = err_q;
  assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_reg_enable_sequencer.sv
// Drives three sequencer configurations with one stimulus stream and checks them against a schedule model.
module tb_reg_enable_sequencer;
  import reg_enable_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [1:0] req_mode = 2'b00;
  logic [3:0] req_addr = 4'h0;

  always #5 clk = ~clk;

  reg_enable_sequencer_if #(.ADDR_W(4), .NUM_REGS(16)) if_a ();
  reg_enable_sequencer_if #(.ADDR_W(4), .NUM_REGS(16)) if_b ();
  reg_enable_sequencer_if #(.ADDR_W(4), .NUM_REGS(12)) if_c ();

  assign if_a.req_valid = req_valid;
  assign if_a.req_mode  = req_mode;
  assign if_a.req_addr  = req_addr;
  assign if_b.req_valid = req_valid;
  assign if_b.req_mode  = req_mode;
  assign if_b.req_addr  = req_addr;
  assign if_c.req_valid = req_valid;
  assign if_c.req_mode  = req_mode;
  assign if_c.req_addr  = req_addr;

  reg_enable_sequencer #(.ADDR_W(4), .NUM_REGS(16), .MSB_FIRST(1)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
  reg_enable_sequencer #(.ADDR_W(4), .NUM_REGS(16), .MSB_FIRST(0)) dut_b (.clk(clk), .rst(rst), .bus(if_b));
  reg_enable_sequencer #(.ADDR_W(4), .NUM_REGS(12), .MSB_FIRST(1)) dut_c (.clk(clk), .rst(rst), .bus(if_c));

  logic [15:0] got_en   [3];
  logic        got_ev   [3];
  logic        got_err  [3];
  logic        got_busy [3];
  logic        got_rdy  [3];

  always_comb begin
    got_en[0] = if_a.enables;          got_en[1] = if_b.enables;          got_en[2] = {4'h0, if_c.enables};
    got_ev[0] = if_a.en_valid;         got_ev[1] = if_b.en_valid;         got_ev[2] = if_c.en_valid;
    got_err[0] = if_a.err;             got_err[1] = if_b.err;             got_err[2] = if_c.err;
    got_busy[0] = if_a.busy;           got_busy[1] = if_b.busy;           got_busy[2] = if_c.busy;
    got_rdy[0] = if_a.req_ready;       got_rdy[1] = if_b.req_ready;       got_rdy[2] = if_c.req_ready;
  end

  // Model: each configuration holds a list of enable vectors still to be emitted.
  int unsigned cfg_n   [3] = '{16, 16, 12};
  bit          cfg_msb [3] = '{1'b1, 1'b0, 1'b1};
  logic [15:0] sched   [3][0:31];
  int          slen    [3] = '{0, 0, 0};
  logic [15:0] exp_en  [3] = '{16'h0, 16'h0, 16'h0};
  bit          exp_ev  [3] = '{1'b0, 1'b0, 1'b0};
  bit          exp_err [3] = '{1'b0, 1'b0, 1'b0};

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  function automatic logic [15:0] oh(int c, int a);
    int sh;
    sh = cfg_msb[c] ? (int'(cfg_n[c]) - 1 - a) : a;
    return 16'(1) << sh;
  endfunction

  function automatic logic [15:0] all_ones(int c);
    logic [31:0] t;
    t = (32'd1 << cfg_n[c]) - 32'd1;
    return t[15:0];
  endfunction

  task automatic model_step();
    for (int c = 0; c < 3; c++) begin
      exp_err[c] = 1'b0;
      if (rst) begin
        slen[c] = 0; exp_en[c] = 16'h0; exp_ev[c] = 1'b0;
      end else begin
        if (req_valid && slen[c] == 0) begin
          case (req_mode)
            MODE_SINGLE: if (int'(req_addr) < int'(cfg_n[c])) begin
                sched[c][0] = oh(c, int'(req_addr)); slen[c] = 1;
              end else exp_err[c] = 1'b1;
            MODE_SWEEP: begin
              for (int k = 0; k < int'(cfg_n[c]); k++) sched[c][k] = oh(c, k);
              slen[c] = int'(cfg_n[c]);
            end
            MODE_BCAST: begin sched[c][0] = all_ones(c); slen[c] = 1; end
            default: exp_err[c] = 1'b1;
          endcase
        end
        if (slen[c] > 0) begin
          exp_en[c] = sched[c][0]; exp_ev[c] = 1'b1;
          for (int k = 1; k < slen[c]; k++) sched[c][k-1] = sched[c][k];
          slen[c]--;
        end else begin
          exp_en[c] = 16'h0; exp_ev[c] = 1'b0;
        end
      end
    end
  endtask

  task automatic step(input bit r, input bit v, input logic [1:0] m, input logic [3:0] a);
    rst = r; req_valid = v; req_mode = m; req_addr = a;
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(i < 2, 1'b0, MODE_SINGLE, 4'h0);
      for (int c = 0; c < 3; c++) begin
        checks++;
        if ({got_en[c], got_ev[c], got_err[c], got_busy[c], got_rdy[c]} !==
            {exp_en[c], exp_ev[c], exp_err[c], exp_ev[c], (slen[c] == 0) && !rst}) begin
          failures++;
          $display("FAIL reset dut%0d cyc=%0d got en=%h v/e/b/r=%b%b%b%b expected en=%h v/e/b/r=%b%b%b%b", c, cyc,
                   got_en[c], got_ev[c], got_err[c], got_busy[c], got_rdy[c], exp_en[c], exp_ev[c], exp_err[c], exp_ev[c], (slen[c] == 0) && !rst);
        end
      end
    end
    checks++;
    if (got_rdy[0] !== 1'b1 || got_en[0] !== 16'h0 || got_busy[0] !== 1'b0) begin
      failures++;
      $display("FAIL reset_defaults got rdy=%b en=%h busy=%b expected rdy=1 en=0000 busy=0", got_rdy[0], got_en[0], got_busy[0]);
    end
  endtask

  task automatic test_single_b2b();
    logic [3:0]  addrs [3] = '{4'd0, 4'd15, 4'd0};
    bit          vals  [3] = '{1'b1, 1'b1, 1'b0};
    logic [15:0] ea    [3] = '{16'h8000, 16'h0001, 16'h0000};
    logic [15:0] eb    [3] = '{16'h0001, 16'h8000, 16'h0000};
    for (int i = 0; i < 3; i++) begin
      step(1'b0, vals[i], MODE_SINGLE, addrs[i]);
      for (int c = 0; c < 3; c++) begin
        checks++;
        if ({got_en[c], got_ev[c], got_err[c], got_busy[c], got_rdy[c]} !==
            {exp_en[c], exp_ev[c], exp_err[c], exp_ev[c], (slen[c] == 0) && !rst}) begin
          failures++;
          $display("FAIL single dut%0d cyc=%0d got en=%h v/e/b/r=%b%b%b%b expected en=%h v/e/b/r=%b%b%b%b", c, cyc,
                   got_en[c], got_ev[c], got_err[c], got_busy[c], got_rdy[c], exp_en[c], exp_ev[c], exp_err[c], exp_ev[c], (slen[c] == 0) && !rst);
        end
      end
      checks++;
      if (got_en[0] !== ea[i] || got_en[1] !== eb[i]) begin
        failures++;
        $display("FAIL single_order step%0d got a=%h b=%h expected a=%h b=%h", i, got_en[0], got_en[1], ea[i], eb[i]);
      end
    end
  endtask

  task automatic test_sweep();
    step(1'b0, 1'b1, MODE_SWEEP, 4'h9);
    for (int k = 0; k <= 17; k++) begin
      if (k > 0) step(1'b0, k <= 16, MODE_SINGLE, 4'd3);
      for (int c = 0; c < 3; c++) begin
        checks++;
        if ({got_en[c], got_ev[c], got_err[c], got_busy[c], got_rdy[c]} !==
            {exp_en[c], exp_ev[c], exp_err[c], exp_ev[c], (slen[c] == 0) && !rst}) begin
          failures++;
          $display("FAIL sweep dut%0d cyc=%0d got en=%h v/e/b/r=%b%b%b%b expected en=%h v/e/b/r=%b%b%b%b", c, cyc,
                   got_en[c], got_ev[c], got_err[c], got_busy[c], got_rdy[c], exp_en[c], exp_ev[c], exp_err[c], exp_ev[c], (slen[c] == 0) && !rst);
        end
      end
      if (k < 16) begin
        checks++;
        if (got_en[0] !== (16'h8000 >> k) || got_en[1] !== (16'h0001 << k) || got_rdy[0] !== (k == 15) || got_busy[0] !== 1'b1) begin
          failures++;
          $display("FAIL sweep_walk k=%0d got a=%h b=%h rdy=%b busy=%b expected a=%h b=%h rdy=%b busy=1", k,
                   got_en[0], got_en[1], got_rdy[0], got_busy[0], 16'h8000 >> k, 16'h0001 << k, k == 15);
        end
      end else if (k == 16) begin
        checks++;
        if (got_en[0] !== 16'h1000 || got_en[1] !== 16'h0008) begin
          failures++;
          $display("FAIL sweep_followon got a=%h b=%h expected a=1000 b=0008", got_en[0], got_en[1]);
        end
      end
    end
  endtask

  task automatic test_range_bcast();
    logic [1:0] modes [3] = '{MODE_SINGLE, MODE_BCAST, MODE_SINGLE};
    bit         vals  [3] = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      step(1'b0, vals[i], modes[i], 4'd12);
      for (int c = 0; c < 3; c++) begin
        checks++;
        if ({got_en[c], got_ev[c], got_err[c], got_busy[c], got_rdy[c]} !==
            {exp_en[c], exp_ev[c], exp_err[c], exp_ev[c], (slen[c] == 0) && !rst}) begin
          failures++;
          $display("FAIL range dut%0d cyc=%0d got en=%h v/e/b/r=%b%b%b%b expected en=%h v/e/b/r=%b%b%b%b", c, cyc,
                   got_en[c], got_ev[c], got_err[c], got_busy[c], got_rdy[c], exp_en[c], exp_ev[c], exp_err[c], exp_ev[c], (slen[c] == 0) && !rst);
        end
      end
      checks++;
      if ((i == 0 && {if_c.err, if_c.en_valid, if_c.enables} !== {1'b1, 1'b0, 12'h000}) ||
          (i == 1 && {if_c.err, if_c.en_valid, if_c.enables} !== {1'b0, 1'b1, 12'hFFF}) ||
          (i == 2 && {if_c.err, if_c.en_valid, if_c.enables} !== {1'b0, 1'b0, 12'h000})) begin
        failures++;
        $display("FAIL range12 step%0d got err=%b ev=%b en=%h", i, if_c.err, if_c.en_valid, if_c.enables);
      end
    end
  endtask

  task automatic test_reserved();
    for (int i = 0; i < 2; i++) begin
      step(1'b0, i == 0, MODE_RSVD, 4'd5);
      for (int c = 0; c < 3; c++) begin
        checks++;
        if ({got_en[c], got_ev[c], got_err[c], got_busy[c], got_rdy[c]} !==
            {exp_en[c], exp_ev[c], exp_err[c], exp_ev[c], (slen[c] == 0) && !rst}) begin
          failures++;
          $display("FAIL reserved dut%0d cyc=%0d got en=%h v/e/b/r=%b%b%b%b expected en=%h v/e/b/r=%b%b%b%b", c, cyc,
                   got_en[c], got_ev[c], got_err[c], got_busy[c], got_rdy[c], exp_en[c], exp_ev[c], exp_err[c], exp_ev[c], (slen[c] == 0) && !rst);
        end
      end
      checks++;
      if (got_err[0] !== (i == 0) || got_busy[0] !== 1'b0 || got_ev[0] !== 1'b0) begin
        failures++;
        $display("FAIL reserved_err step%0d got err=%b busy=%b ev=%b expected err=%b busy=0 ev=0", i, got_err[0], got_busy[0], got_ev[0], i == 0);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    for (int i = 0; i < 24; i++) begin
      // Sweep cycles 0..3, reset during the 5th, then a fresh sweep that must restart at index 0.
      step(i == 4, (i == 0) || (i == 6), MODE_SWEEP, 4'h7);
      for (int c = 0; c < 3; c++) begin
        checks++;
        if ({got_en[c], got_ev[c], got_err[c], got_busy[c], got_rdy[c]} !==
            {exp_en[c], exp_ev[c], exp_err[c], exp_ev[c], (slen[c] == 0) && !rst}) begin
          failures++;
          $display("FAIL rst_sweep dut%0d cyc=%0d got en=%h v/e/b/r=%b%b%b%b expected en=%h v/e/b/r=%b%b%b%b", c, cyc,
                   got_en[c], got_ev[c], got_err[c], got_busy[c], got_rdy[c], exp_en[c], exp_ev[c], exp_err[c], exp_ev[c], (slen[c] == 0) && !rst);
        end
      end
      if (i == 4 || i == 5) begin
        checks++;
        if (got_en[0] !== 16'h0 || got_busy[0] !== 1'b0 || got_ev[0] !== 1'b0) begin
          failures++;
          $display("FAIL rst_abandon step%0d got en=%h busy=%b ev=%b expected 0", i, got_en[0], got_busy[0], got_ev[0]);
        end
      end else if (i == 6) begin
        checks++;
        if (got_en[0] !== 16'h8000 || got_en[1] !== 16'h0001) begin
          failures++;
          $display("FAIL rst_restart got a=%h b=%h expected a=8000 b=0001", got_en[0], got_en[1]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
      for (int c = 0; c < 3; c++) begin
        checks++;
        if ({got_en[c], got_ev[c], got_err[c], got_busy[c], got_rdy[c]} !==
            {exp_en[c], exp_ev[c], exp_err[c], exp_ev[c], (slen[c] == 0) && !rst}) begin
          failures++;
          $display("FAIL random dut%0d cyc=%0d got en=%h v/e/b/r=%b%b%b%b expected en=%h v/e/b/r=%b%b%b%b", c, cyc,
                   got_en[c], got_ev[c], got_err[c], got_busy[c], got_rdy[c], exp_en[c], exp_ev[c], exp_err[c], exp_ev[c], (slen[c] == 0) && !rst);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_b2b();
    test_sweep();
    test_range_bcast();
    test_reserved();
    test_reset_mid_sweep();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/reg_enable_sequencer.md
Name: reg_enable_sequencer

Overview:
- Parametrised, registered successor to the team's 4-to-16 one-hot register-enable decoder.
- Accepts register-write requests over a valid/ready handshake.
- Drives a one-cycle-per-target one-hot (or all-ones) enable vector to the register file.
- Adds a sweep mode that walks every register, one per cycle, to clear or initialise the file.
- Flags out-of-range addresses and reserved modes.

Parameters:
- ADDR_W, 4, width of the register address.
- NUM_REGS, 16, number of enable lines. Must satisfy 1 <= NUM_REGS <= 2**ADDR_W.
- MSB_FIRST, 1. When 1, address 0 maps to enables[NUM_REGS-1] (legacy ordering). When 0, address k maps to enables[k].

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- req_addr  input  ADDR_W  target register address.
- req_mode  input  2  operation: 00 SINGLE, 01 SWEEP, 10 BCAST, 11 reserved.
- enables  output  NUM_REGS  registered enable vector.
- en_valid  output  1  high in every cycle in which enables is driven by an operation.
- busy  output  1  high while the FSM is not in IDLE.
- err  output  1  one-cycle pulse on a rejected request.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
  - On rst: state=IDLE, enables=0, en_valid=0, busy=0, err=0, sweep counter=0.
  - rst mid-operation (including mid-sweep) abandons the operation. In the cycle after rst, all outputs are zero and req_ready=1 once rst is deasserted.
- Handshake: a request is accepted on a clk edge where req_valid && req_ready. Accepted fields are sampled only on that edge.
- Latency: response is registered.
  - Request accepted at edge t gives its first enables/en_valid at t+1 (visible after edge t).
  - With no new request, enables returns to 0 the cycle after the operation ends. enables is 0 whenever en_valid=0.
- States:
  - IDLE
    - Accept SINGLE with addr < NUM_REGS -> SINGLE.
    - Accept SWEEP -> SWEEP with counter=0; req_addr is ignored.
    - Accept BCAST -> BCAST.
    - Accept reserved mode or addr >= NUM_REGS (SINGLE only) -> stay IDLE. err=1 for one cycle, enables=0, en_valid=0.
  - SINGLE: enables = one-hot of addr, en_valid=1, for exactly one cycle.
  - BCAST: enables = all ones, en_valid=1, for exactly one cycle.
  - SWEEP: enables = one-hot of counter, en_valid=1.
    - counter increments each cycle from 0 to NUM_REGS-1. Exactly NUM_REGS cycles, no skips, no wrap.
    - After the NUM_REGS-1 cycle, go to IDLE unless a new request is accepted.
- req_ready:
  - 1 in IDLE, SINGLE and BCAST.
  - 1 in SWEEP only when counter == NUM_REGS-1. Otherwise 0.
  - 0 in the cycle rst is high.
- Back-to-back: a request accepted in the last cycle of an operation starts its output on the next cycle, with no gap. Sustained SINGLE requests therefore give one enable per cycle.
- Rejected requests:
  - Are accepted, i.e. consumed, and produce no enable.
  - If rejected during the last cycle of an operation, the FSM goes to IDLE and err pulses on the next cycle.
- busy = (state != IDLE).
- err is never asserted together with en_valid.
- Ordering:
  - MSB_FIRST=1: one-hot of a is enables[NUM_REGS-1-a].
  - MSB_FIRST=0: one-hot of a is enables[a].
- Width rule: the address comparison against NUM_REGS uses ADDR_W+1 bits, so that NUM_REGS == 2**ADDR_W is correct.

Decomposition:
- Package reg_enable_pkg:
  - Mode constants MODE_SINGLE=2'b00, MODE_SWEEP=2'b01, MODE_BCAST=2'b10, MODE_RSVD=2'b11.
  - FSM state encoding: IDLE, SINGLE, SWEEP, BCAST.
- Sub-module onehot_decode (combinational; parameters ADDR_W, NUM_REGS, MSB_FIRST; addr in, onehot out, out-of-range gives all zero).
  - Instantiated once.
  - Fed by a mux of the accepted address or the sweep counter.

Test Plan:
1. Defaults: rst high 2 cycles, then low -> enables=16'h0000, en_valid=0, busy=0, err=0, req_ready=1.
2. SINGLE addr=0 then addr=15, back-to-back -> enables=16'h8000 then 16'h0001 on consecutive cycles, no gap. With MSB_FIRST=0 -> 16'h0001 then 16'h8000.
3. SWEEP -> 16 consecutive cycles 16'h8000, 16'h4000 ... 16'h0001.
   - req_ready=0 except in the final sweep cycle.
   - busy=1 throughout.
   - A SINGLE addr=3 held valid is accepted in the final cycle and gives 16'h1000 immediately after.
4. NUM_REGS=12, ADDR_W=4, SINGLE addr=12 -> err pulse 1 cycle, enables=0, en_valid=0. BCAST -> enables=12'hFFF for one cycle.
5. Reserved mode 2'b11 -> err=1 one cycle, state stays IDLE, busy=0.
6. rst asserted on 5th sweep cycle -> next cycle enables=0, busy=0, en_valid=0. A new SWEEP after reset restarts at the address-0 enable.
